// File: rtl/any1_bitfield_arb_if.sv
// Signal bundle between the issue ports, the bitfield arbiter and the shared bitfield unit.
// slave = arbiter side, master = issue logic / bitfield unit side.
interface any1_bitfield_arb_if #(
  parameter int NREQ   = 2,
  parameter int DWIDTH = 64,
  parameter int TAGW   = 6
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [NREQ*3-1:0]      req_op_i;
  logic [NREQ*DWIDTH-1:0] req_a_i;
  logic [NREQ*DWIDTH-1:0] req_b_i;
  logic [NREQ*DWIDTH-1:0] req_c_i;
  logic [NREQ*DWIDTH-1:0] req_d_i;
  logic [NREQ*TAGW-1:0]   req_tag_i;

  logic [2:0]             bf_op_o;
  logic [DWIDTH-1:0]      bf_a_o;
  logic [DWIDTH-1:0]      bf_b_o;
  logic [DWIDTH-1:0]      bf_c_o;
  logic [DWIDTH-1:0]      bf_d_o;
  logic [DWIDTH-1:0]      bf_res_i;

  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [IDW-1:0]         rsp_id_o;
  logic [TAGW-1:0]        rsp_tag_o;
  logic [DWIDTH-1:0]      rsp_res_o;
  logic                   rsp_err_o;
  logic                   busy_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i, req_d_i, req_tag_i,
    input  bf_res_i, rsp_ready_i,
    output req_ready_o, bf_op_o, bf_a_o, bf_b_o, bf_c_o, bf_d_o,
    output rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_res_o, rsp_err_o, busy_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i, req_d_i, req_tag_i,
    output bf_res_i, rsp_ready_i,
    input  req_ready_o, bf_op_o, bf_a_o, bf_b_o, bf_c_o, bf_d_o,
    input  rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_res_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/any1_bitfield_arb.sv
// Round-robin arbiter feeding one shared combinational bitfield unit through an
// issue register (S1, drives bf_*) and a result register (S2, drives rsp_*).
module any1_bitfield_arb #(
  parameter int NREQ   = 2,
  parameter int DWIDTH = 64,
  parameter int TAGW   = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  any1_bitfield_arb_if.slave bus
);
  localparam int         IDW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  logic              s1_v;
  logic              s2_v;
  logic              adv1;
  logic              adv2;
  logic              any_req;
  logic              accept;
  logic [IDW-1:0]    rr_q;
  logic [IDW-1:0]    win;
  logic [TAGW-1:0]   s1_tag;
  logic [IDW-1:0]    s1_id;

  logic [2:0]        op_arr  [NREQ];
  logic [DWIDTH-1:0] a_arr   [NREQ];
  logic [DWIDTH-1:0] b_arr   [NREQ];
  logic [DWIDTH-1:0] c_arr   [NREQ];
  logic [DWIDTH-1:0] d_arr   [NREQ];
  logic [TAGW-1:0]   tag_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g]  = bus.req_op_i[g*3 +: 3];
    assign a_arr[g]   = bus.req_a_i[g*DWIDTH +: DWIDTH];
    assign b_arr[g]   = bus.req_b_i[g*DWIDTH +: DWIDTH];
    assign c_arr[g]   = bus.req_c_i[g*DWIDTH +: DWIDTH];
    assign d_arr[g]   = bus.req_d_i[g*DWIDTH +: DWIDTH];
    assign tag_arr[g] = bus.req_tag_i[g*TAGW +: TAGW];
  end

  // Pipeline advance: S2 can take new data when empty or being drained,
  // S1 when empty or when it can move into S2.
  assign adv2 = !s2_v || bus.rsp_ready_i;
  assign adv1 = !s1_v || adv2;

  always_comb begin : arbitrate
    logic [IDW-1:0] cand;
    win     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((k + 32'(rr_q)) % 32'(NREQ));
      if (!any_req && bus.req_valid_i[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  // Ready is built from stage occupancy and valids only, never from its own value.
  assign accept = any_req && adv1 && !flush_i && rst_ni;

  always_comb begin : grant
    bus.req_ready_o = '0;
    if (accept) begin
      bus.req_ready_o[win] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : rr_reg
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (accept) begin
      rr_q <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : s1_reg
    if (!rst_ni) begin
      s1_v        <= 1'b0;
      s1_tag      <= '0;
      s1_id       <= '0;
      bus.bf_op_o <= '0;
      bus.bf_a_o  <= '0;
      bus.bf_b_o  <= '0;
      bus.bf_c_o  <= '0;
      bus.bf_d_o  <= '0;
    end else begin
      if (flush_i) begin
        s1_v <= 1'b0;
      end else if (accept) begin
        s1_v <= 1'b1;
      end else if (adv2) begin
        s1_v <= 1'b0;
      end
      // Operands only change on accept so the unit sees stable inputs while idle.
      if (accept) begin
        s1_tag      <= tag_arr[win];
        s1_id       <= win;
        bus.bf_op_o <= op_arr[win];
        bus.bf_a_o  <= a_arr[win];
        bus.bf_b_o  <= b_arr[win];
        bus.bf_c_o  <= c_arr[win];
        bus.bf_d_o  <= d_arr[win];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : s2_reg
    if (!rst_ni) begin
      s2_v          <= 1'b0;
      bus.rsp_id_o  <= '0;
      bus.rsp_tag_o <= '0;
      bus.rsp_res_o <= '0;
      bus.rsp_err_o <= 1'b0;
    end else begin
      if (flush_i) begin
        s2_v <= 1'b0;
      end else if (s1_v && adv2) begin
        s2_v <= 1'b1;
      end else if (bus.rsp_ready_i) begin
        s2_v <= 1'b0;
      end
      if (!flush_i && s1_v && adv2) begin
        bus.rsp_id_o  <= s1_id;
        bus.rsp_tag_o <= s1_tag;
        bus.rsp_err_o <= (bus.bf_op_o == OP_ILLEGAL);
        bus.rsp_res_o <= (bus.bf_op_o == OP_ILLEGAL) ? '0 : bus.bf_res_i;
      end
    end
  end

  assign bus.rsp_valid_o = s2_v;
  assign bus.busy_o      = s1_v || s2_v;

endmodule

// File: tb/tb_any1_bitfield_arb.sv
// Bench for any1_bitfield_arb: behavioural bitfield unit, transaction-level
// pipeline/arbitration model, directed scenarios followed by random traffic.
module tb_any1_bitfield_arb;
  localparam int N  = 3;
  localparam int DW = 64;
  localparam int TW = 6;
  localparam int IW = 2;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a, b, c, d;
    logic [TW-1:0] tag;
    logic [IW-1:0] id;
    logic [DW-1:0] res;
    logic          err;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit    pend [N];
  item_t preq [N];
  bit    m_s1, m_s2;
  item_t m_s1i, m_s2i;
  int    m_rr;
  int    last_grant;
  int    got_id[$];
  int    got_cyc[$];

  function automatic logic [DW-1:0] bf_model(input logic [2:0] op,
                                             input logic [DW-1:0] a, b, c, d);
    int unsigned   off, w;
    logic [DW-1:0] fm, m, f;
    off = int'(c[5:0]);
    w   = int'(d[5:0]) + 1;
    fm  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    m   = fm << off;
    f   = (a >> off) & fm;
    case (op)
      3'd0: return a | m;
      3'd1: return a & ~m;
      3'd2: return a ^ m;
      3'd3: return (a & ~m) | ((b << off) & m);
      3'd4: return (((f >> (w - 1)) & 64'd1) != 0) ? (f | ~fm) : f;
      3'd5: return f;
      3'd6: begin
        for (int i = 0; i < 64; i++) if (((a >> i) & 64'd1) != 0) return 64'(i);
        return 64'd64;
      end
      default: return 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  endfunction

  any1_bitfield_arb_if #(.NREQ(N), .DWIDTH(DW), .TAGW(TW)) bus ();

  any1_bitfield_arb #(.NREQ(N), .DWIDTH(DW), .TAGW(TW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.bf_res_i = bf_model(bus.bf_op_o, bus.bf_a_o, bus.bf_b_o, bus.bf_c_o, bus.bf_d_o);

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid_i[i]           = pend[i];
      bus.req_op_i[i*3 +: 3]       = preq[i].op;
      bus.req_a_i[i*DW +: DW]      = preq[i].a;
      bus.req_b_i[i*DW +: DW]      = preq[i].b;
      bus.req_c_i[i*DW +: DW]      = preq[i].c;
      bus.req_d_i[i*DW +: DW]      = preq[i].d;
      bus.req_tag_i[i*TW +: TW]    = preq[i].tag;
    end
  endtask

  task automatic post(input int i, input logic [2:0] op, input logic [63:0] a, b, c, d,
                      input logic [TW-1:0] tag);
    preq[i].op  = op;
    preq[i].a   = a;
    preq[i].b   = b;
    preq[i].c   = c;
    preq[i].d   = d;
    preq[i].tag = tag;
    preq[i].id  = IW'(i);
    preq[i].err = (op == 3'd7);
    preq[i].res = (op == 3'd7) ? '0 : bf_model(op, a, b, c, d);
    pend[i]     = 1'b1;
  endtask

  task automatic rpost(input int i);
    logic [2:0] op;
    op = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
    post(i, op, {$urandom, $urandom}, {$urandom, $urandom},
         64'($urandom_range(0, 63)), 64'($urandom_range(0, 63)), TW'($urandom));
  endtask

  // One clock: drive at the falling edge, check settled outputs, advance the model.
  task automatic step(input bit rdy, input bit fl);
    int            w;
    bit            adv1, adv2, acc;
    logic [N-1:0]  er;
    bus.rsp_ready_i = rdy;
    flush           = fl;
    drive();
    #1;
    w = -1;
    for (int k = 0; k < N; k++) if (w < 0 && pend[(m_rr + k) % N]) w = (m_rr + k) % N;
    adv2 = !m_s2 || rdy;
    adv1 = !m_s1 || adv2;
    acc  = (w >= 0) && adv1 && !fl;
    er   = acc ? (N'(1) << w) : '0;
    chk("ready", 64'(bus.req_ready_o), 64'(er));
    chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(m_s2));
    chk("busy", 64'(bus.busy_o), 64'(m_s1 || m_s2));
    if (m_s2) begin
      chk("rsp_id", 64'(bus.rsp_id_o), 64'(m_s2i.id));
      chk("rsp_tag", 64'(bus.rsp_tag_o), 64'(m_s2i.tag));
      chk("rsp_res", bus.rsp_res_o, m_s2i.res);
      chk("rsp_err", 64'(bus.rsp_err_o), 64'(m_s2i.err));
    end
    if (m_s1) begin
      chk("bf_op", 64'(bus.bf_op_o), 64'(m_s1i.op));
      chk("bf_a", bus.bf_a_o, m_s1i.a);
      chk("bf_b", bus.bf_b_o, m_s1i.b);
      chk("bf_c", bus.bf_c_o, m_s1i.c);
      chk("bf_d", bus.bf_d_o, m_s1i.d);
    end
    last_grant = acc ? w : -1;
    if (fl) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
    end else begin
      if (m_s2 && rdy) begin
        got_id.push_back(int'(m_s2i.id));
        got_cyc.push_back(cyc);
      end
      if (m_s1 && adv2) begin
        m_s2  = 1'b1;
        m_s2i = m_s1i;
      end else if (rdy) begin
        m_s2 = 1'b0;
      end
      if (acc) begin
        m_s1    = 1'b1;
        m_s1i   = preq[w];
        pend[w] = 1'b0;
        m_rr    = (w + 1) % N;
      end else if (adv2) begin
        m_s1 = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      preq[i] = '{op: '0, a: '0, b: '0, c: '0, d: '0, tag: '0, id: '0, res: '0, err: 1'b0};
    end
    drive();
    m_s1 = 1'b0; m_s2 = 1'b0; m_rr = 0; last_grant = -1;

    // Reset state
    @(negedge clk); #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_bf_op", 64'(bus.bf_op_o), 64'd0);
    chk("rst_bf_a", bus.bf_a_o, 64'd0);
    chk("rst_rsp_res", bus.rsp_res_o, 64'd0);
    chk("rst_rsp_tag", 64'(bus.rsp_tag_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single SET from req0, two-cycle latency
    post(0, 3'd0, 64'd0, 64'd0, 64'd4, 64'd3, 6'd5);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("t1_valid", 64'(bus.rsp_valid_o), 64'd1);
    chk("t1_res", bus.rsp_res_o, 64'hF0);
    chk("t1_id", 64'(bus.rsp_id_o), 64'd0);
    chk("t1_tag", 64'(bus.rsp_tag_o), 64'd5);
    chk("t1_err", 64'(bus.rsp_err_o), 64'd0);
    step(1'b1, 1'b0);

    // EXTU from req1, 12-bit field at offset 4
    post(1, 3'd5, 64'h1234, 64'd0, 64'd4, 64'd11, 6'd3);
    step(1'b1, 1'b0);
    chk("t2_bf_c", bus.bf_c_o, 64'd4);
    chk("t2_bf_op", 64'(bus.bf_op_o), 64'd5);
    step(1'b1, 1'b0);
    chk("t2_res", bus.rsp_res_o, 64'h123);
    chk("t2_id", 64'(bus.rsp_id_o), 64'd1);
    step(1'b1, 1'b0);

    // Two requesters continuously valid: alternating grants, no bubbles
    got_id.delete(); got_cyc.delete();
    bus.rsp_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (!pend[0]) rpost(0);
      if (!pend[1]) rpost(1);
      drive(); #1;
      chk("alt_ready", 64'(bus.req_ready_o), 64'(N'(1) << (k % 2)));
      step(1'b1, 1'b0);
    end
    drain(4);
    chk("alt_count", 64'(got_id.size() >= 6), 64'd1);
    for (int k = 0; k < 6 && k < got_id.size(); k++) begin
      chk("alt_rsp_id", 64'(got_id[k]), 64'(k % 2));
      chk("alt_rsp_cyc", 64'(got_cyc[k]), 64'(got_cyc[0] + k));
    end

    // Backpressure with full pipe, then release
    rpost(0); rpost(1); rpost(2);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    got_id.delete(); got_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      bus.rsp_ready_i = 1'b0;
      drive(); #1;
      chk("bp_ready", 64'(bus.req_ready_o), 64'd0);
      step(1'b0, 1'b0);
    end
    drain(5);
    chk("bp_count", 64'(got_id.size() >= 2), 64'd1);
    if (got_cyc.size() >= 2) chk("bp_b2b", 64'(got_cyc[1]), 64'(got_cyc[0] + 1));

    // Illegal op then legal op
    post(0, 3'd7, 64'hFFFF, 64'd0, 64'd0, 64'd7, 6'd9);
    step(1'b1, 1'b0);
    post(0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 6'd10);
    step(1'b1, 1'b0);
    chk("ill_err", 64'(bus.rsp_err_o), 64'd1);
    chk("ill_res", bus.rsp_res_o, 64'd0);
    chk("ill_tag", 64'(bus.rsp_tag_o), 64'd9);
    step(1'b1, 1'b0);
    chk("legal_err", 64'(bus.rsp_err_o), 64'd0);
    chk("legal_res", bus.rsp_res_o, 64'd1);
    drain(3);

    // Async reset with both stages full and rr pointer at 1
    post(1, 3'd2, 64'h55, 64'd0, 64'd1, 64'd2, 6'd1);
    step(1'b0, 1'b0);
    post(0, 3'd1, 64'hFF, 64'd0, 64'd0, 64'd3, 6'd2);
    step(1'b0, 1'b0);
    post(2, 3'd5, 64'hABCD, 64'd0, 64'd8, 64'd7, 6'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("arst_busy", 64'(bus.busy_o), 64'd0);
    chk("arst_ready", 64'(bus.req_ready_o), 64'd0);
    chk("arst_bf_a", bus.bf_a_o, 64'd0);
    m_s1 = 1'b0; m_s2 = 1'b0; m_rr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    post(0, 3'd0, 64'd0, 64'd0, 64'd8, 64'd0, 6'd4);
    post(1, 3'd0, 64'd0, 64'd0, 64'd9, 64'd0, 6'd5);
    bus.rsp_ready_i = 1'b1;
    drive(); #1;
    chk("arst_next_grant", 64'(bus.req_ready_o), 64'b001);
    drain(8);

    // Flush with both stages full; rr pointer survives
    post(1, 3'd0, 64'd0, 64'd0, 64'd2, 64'd1, 6'd11);
    step(1'b0, 1'b0);
    post(0, 3'd0, 64'd0, 64'd0, 64'd3, 64'd1, 6'd12);
    step(1'b0, 1'b0);
    post(1, 3'd3, 64'hF0F0, 64'h3, 64'd4, 64'd1, 6'd13);
    post(2, 3'd4, 64'h80, 64'd0, 64'd4, 64'd3, 6'd14);
    step(1'b0, 1'b1);
    chk("flush_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("flush_busy", 64'(bus.busy_o), 64'd0);
    bus.rsp_ready_i = 1'b1;
    flush = 1'b0;
    drive(); #1;
    chk("flush_rr_kept", 64'(bus.req_ready_o), 64'b010);
    drain(8);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 2) == 0) rpost(i);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end
    drain(12);
    chk("end_idle", 64'(bus.busy_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
